// File: rtl/tsqr_pkg.sv
// Shared constants and types for the TSQR tile front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tsqr_pkg;

   localparam int MATRIX_WIDTH   = 8;    // rows per tile
   localparam int RAM_WIDTH      = 256;  // one ug/pg row word
   localparam int CNT_WIDTH      = 16;   // tile count width
   localparam int RAM_ADDR_WIDTH = 16;   // source memory address width
   localparam int CREDIT_WIDTH   = 4;    // tile-finished credit counter width

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FEED    = 2'd1,
      WAIT_FI = 2'd2,
      DRAIN   = 2'd3
   } feeder_state_t;

   // Per-row scalars travel together through the output register.
   typedef struct packed {
      logic [31:0] e_ug;
      logic [31:0] e_pg;
      logic [31:0] e_upg;
   } tsqr_scalars_t;

endpackage

// File: rtl/tsqr_credit_cnt.sv
// Saturating up/down credit counter; simultaneous inc and dec cancel out.
// Latency: count updates on the next clock edge; cnt_nxt exposes the pending value.
// Backpressure: none; saturates at all-ones and at zero instead of wrapping.
module tsqr_credit_cnt #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] cnt,
   output logic [WIDTH-1:0] cnt_nxt
);

   // Next count: load wins, then a lone inc or a lone dec, saturating at both ends.
   always_comb begin
      cnt_nxt = cnt;
      if (load) begin
         cnt_nxt = load_val;
      end else if (inc && !dec) begin
         if (cnt != '1) cnt_nxt = cnt + WIDTH'(1);
      end else if (dec && !inc) begin
         if (cnt != '0) cnt_nxt = cnt - WIDTH'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_nxt;
   end

endmodule

// File: rtl/tsqr_tile_feeder.sv
// Streams U/P tiles from a source row memory into the TSQR core; tile 0 also carries e_* scalars.
// Latency: first row reaches ug_i two cycles after start; one row per cycle while credits last.
// Backpressure: after PRELOAD tiles, each new tile waits for a core_tile_fi credit (WAIT_FI stalls reads).
module tsqr_tile_feeder #(
   parameter int MATRIX_WIDTH = tsqr_pkg::MATRIX_WIDTH,
   parameter int RAM_WIDTH    = tsqr_pkg::RAM_WIDTH,
   parameter int CNT_WIDTH    = tsqr_pkg::CNT_WIDTH,
   parameter int ADDR_WIDTH   = tsqr_pkg::RAM_ADDR_WIDTH,
   parameter int PRELOAD      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  tile_no,
   input  logic                  core_tile_fi,
   output logic                  src_rd_en,
   output logic [ADDR_WIDTH-1:0] src_rd_addr,
   input  logic [RAM_WIDTH-1:0]  src_ug_data,
   input  logic [RAM_WIDTH-1:0]  src_pg_data,
   input  logic [31:0]           src_e_ug,
   input  logic [31:0]           src_e_pg,
   input  logic [31:0]           src_e_upg,
   output logic [RAM_WIDTH-1:0]  ug_i,
   output logic [RAM_WIDTH-1:0]  pg_i,
   output logic                  ug_ready,
   output logic                  pg_ready,
   output logic [31:0]           e_ug,
   output logic [31:0]           e_pg,
   output logic [31:0]           e_upg,
   output logic                  e_ug_ready,
   output logic                  e_pg_ready,
   output logic                  e_upg_ready,
   output logic                  busy,
   output logic                  done
);
   import tsqr_pkg::*;

   // MATRIX_WIDTH must be a power of two: the row index is the low address bits.
   localparam int ROW_W  = $clog2(MATRIX_WIDTH);
   localparam int CRED_W = CREDIT_WIDTH;

   feeder_state_t         state;
   logic [CNT_WIDTH-1:0]  tile_total;
   logic [CNT_WIDTH-1:0]  tile_idx;
   logic [ROW_W-1:0]      row_idx;
   logic [CRED_W-1:0]     credits;
   logic [CRED_W-1:0]     credits_nxt;
   logic                  accept;
   logic                  last_row;
   logic                  last_tile;
   logic                  row_vld_q;
   logic                  e_vld_q;
   logic [RAM_WIDTH-1:0]  ug_q;
   logic [RAM_WIDTH-1:0]  pg_q;
   tsqr_scalars_t         scal_q;
   logic [CNT_WIDTH+ROW_W-1:0] addr_full;

   assign accept    = (state == IDLE) && start && (tile_no != '0);
   assign last_row  = (row_idx == ROW_W'(MATRIX_WIDTH - 1));
   assign last_tile = (tile_idx == tile_total - CNT_WIDTH'(1));

   assign src_rd_en   = (state == FEED);
   assign addr_full   = {tile_idx, row_idx};
   assign src_rd_addr = ADDR_WIDTH'(addr_full);
   assign busy        = (state != IDLE);

   // One credit is spent on each tile's row-0 read; fi pulses only count once launched.
   tsqr_credit_cnt #(.WIDTH(CRED_W)) u_credit (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (CRED_W'(PRELOAD)),
      .inc      (core_tile_fi && (state != IDLE)),
      .dec      (src_rd_en && (row_idx == '0)),
      .cnt      (credits),
      .cnt_nxt  (credits_nxt)
   );

   // Sequencer: launch, per-row read walk, credit gating between tiles, drain and done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tile_total <= '0;
         tile_idx   <= '0;
         row_idx    <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (tile_no != '0) begin
                     tile_total <= tile_no;
                     tile_idx   <= '0;
                     row_idx    <= '0;
                     state      <= FEED;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            FEED: begin
               row_idx <= row_idx + ROW_W'(1);
               if (last_row) begin
                  if (last_tile) begin
                     state <= DRAIN;
                  end else begin
                     tile_idx <= tile_idx + CNT_WIDTH'(1);
                     // Include an fi arriving this very cycle so it does not cost a bubble.
                     state    <= (credits_nxt != '0) ? FEED : WAIT_FI;
                  end
               end
            end
            WAIT_FI: begin
               if (credits != '0) state <= FEED;
            end
            DRAIN: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output register: capture returned row data on the edge closing each read cycle, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_vld_q <= 1'b0;
         e_vld_q   <= 1'b0;
         ug_q      <= '0;
         pg_q      <= '0;
         scal_q    <= '0;
      end else begin
         row_vld_q <= src_rd_en;
         e_vld_q   <= src_rd_en && (tile_idx == '0);
         if (src_rd_en) begin
            ug_q         <= src_ug_data;
            pg_q         <= src_pg_data;
            scal_q.e_ug  <= src_e_ug;
            scal_q.e_pg  <= src_e_pg;
            scal_q.e_upg <= src_e_upg;
         end
      end
   end

   assign ug_i        = ug_q;
   assign pg_i        = pg_q;
   assign ug_ready    = row_vld_q;
   assign pg_ready    = row_vld_q;
   assign e_ug        = scal_q.e_ug;
   assign e_pg        = scal_q.e_pg;
   assign e_upg       = scal_q.e_upg;
   assign e_ug_ready  = e_vld_q;
   assign e_pg_ready  = e_vld_q;
   assign e_upg_ready = e_vld_q;

endmodule

// File: tb/tb_tsqr_tile_feeder.sv
// Directed bench for tsqr_tile_feeder with a row scoreboard and cycle-timing checks.
// Latency: n/a.
// Backpressure: core_tile_fi is pulsed by the bench at chosen cycles.
module tb_tsqr_tile_feeder;

   localparam int RW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [15:0]   tile_no;
   logic          core_tile_fi;
   logic          src_rd_en;
   logic [15:0]   src_rd_addr;
   logic [RW-1:0] src_ug_data, src_pg_data;
   logic [31:0]   src_e_ug, src_e_pg, src_e_upg;
   logic [RW-1:0] ug_i, pg_i;
   logic          ug_ready, pg_ready;
   logic [31:0]   e_ug, e_pg, e_upg;
   logic          e_ug_ready, e_pg_ready, e_upg_ready;
   logic          busy, done;

   always #5 clk = ~clk;

   tsqr_tile_feeder #(.PRELOAD(3)) dut (
      .clk(clk), .rst(rst), .start(start), .tile_no(tile_no), .core_tile_fi(core_tile_fi),
      .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr),
      .src_ug_data(src_ug_data), .src_pg_data(src_pg_data),
      .src_e_ug(src_e_ug), .src_e_pg(src_e_pg), .src_e_upg(src_e_upg),
      .ug_i(ug_i), .pg_i(pg_i), .ug_ready(ug_ready), .pg_ready(pg_ready),
      .e_ug(e_ug), .e_pg(e_pg), .e_upg(e_upg),
      .e_ug_ready(e_ug_ready), .e_pg_ready(e_pg_ready), .e_upg_ready(e_upg_ready),
      .busy(busy), .done(done)
   );

   // Source memory contents are a pure function of the address.
   function automatic logic [RW-1:0] mk_ug(input logic [15:0] a);
      return {8{a, 16'hC0DE}};
   endfunction
   function automatic logic [RW-1:0] mk_pg(input logic [15:0] a);
      return {8{16'hBEEF, ~a}};
   endfunction

   assign src_ug_data = mk_ug(src_rd_addr);
   assign src_pg_data = mk_pg(src_rd_addr);
   assign src_e_ug    = {16'h0E01, src_rd_addr};
   assign src_e_pg    = {16'h0E02, src_rd_addr};
   assign src_e_upg   = {16'h0E03, src_rd_addr};

   typedef struct {
      logic [RW-1:0] ug;
      logic [RW-1:0] pg;
      logic [31:0]   eu, ep, eup;
      logic          evld;
   } exp_t;

   exp_t sb[$];
   exp_t mon_item;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Run log collected by the monitor.
   int ready_cnt, rd_cnt, e_cnt, done_cnt, busy_cnt;
   int first_ready_cyc, last_rd_cyc, done_cyc, seg_len;
   int rd_rise_q[$];
   int seg_q[$];
   logic prev_rd = 1'b0, prev_ready = 1'b0, rst_at_edge = 1'b0;

   task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input int ntiles);
      exp_t e;
      for (int i = 0; i < ntiles * 8; i++) begin
         e.ug   = mk_ug(16'(i));
         e.pg   = mk_pg(16'(i));
         e.eu   = {16'h0E01, 16'(i)};
         e.ep   = {16'h0E02, 16'(i)};
         e.eup  = {16'h0E03, 16'(i)};
         e.evld = (i < 8);
         sb.push_back(e);
      end
   endtask

   task automatic clear_log();
      ready_cnt = 0; rd_cnt = 0; e_cnt = 0; done_cnt = 0; busy_cnt = 0;
      first_ready_cyc = -1; last_rd_cyc = -1; done_cyc = -1; seg_len = 0;
      rd_rise_q.delete();
      seg_q.delete();
   endtask

   task automatic pulse_start(input logic [15:0] n, output int c);
      tile_no = n;
      start   = 1'b1;
      c       = cyc;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic pulse_fi_at(input int target);
      while (cyc < target) @(negedge clk);
      core_tile_fi = 1'b1;
      @(negedge clk);
      core_tile_fi = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while (done_cnt == 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done_seen"}, done_cnt != 0, 1);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_data"}, ug_i | pg_i, 0);
      check({tag, "_scal"}, {e_ug, e_pg, e_upg}, 0);
      check({tag, "_strb"}, {ug_ready, pg_ready, e_ug_ready, e_pg_ready, e_upg_ready,
                             src_rd_en, busy, done}, 0);
      check({tag, "_addr"}, src_rd_addr, 0);
   endtask

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= rst;
   end

   // Monitor: scoreboard pops on ready, strobe consistency, timing log.
   always @(negedge clk) begin
      if (ug_ready) begin
         if (first_ready_cyc < 0) first_ready_cyc = cyc;
         ready_cnt++;
         seg_len++;
         if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            mon_item = sb.pop_front();
            check("ug_i", ug_i, mon_item.ug);
            check("pg_i", pg_i, mon_item.pg);
            check("e_ug", e_ug, mon_item.eu);
            check("e_pg", e_pg, mon_item.ep);
            check("e_upg", e_upg, mon_item.eup);
            check("e_ready", e_ug_ready, mon_item.evld);
         end
      end else if (prev_ready) begin
         seg_q.push_back(seg_len);
         seg_len = 0;
      end
      check("pg_ready_eq", pg_ready, ug_ready);
      check("e_ready_eq", {e_pg_ready, e_upg_ready}, {e_ug_ready, e_ug_ready});
      if (!rst_at_edge) check("ready_lat", ug_ready, prev_rd);
      if (src_rd_en) begin
         rd_cnt++;
         last_rd_cyc = cyc;
         if (!prev_rd) rd_rise_q.push_back(cyc);
      end
      if (e_ug_ready) e_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      prev_rd    = src_rd_en;
      prev_ready = ug_ready;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "timeout");
   end

   initial begin
      int c;
      rst = 1'b1; start = 1'b0; tile_no = '0; core_tile_fi = 1'b0;
      clear_log();
      repeat (2) @(negedge clk);
      check_quiet("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic run: three preloaded tiles, fourth released by an fi 50 cycles after start.
      clear_log();
      push_exp(4);
      pulse_start(16'd4, c);
      check("basic_busy", {busy, src_rd_en}, 2'b11);
      pulse_fi_at(c + 50);
      wait_done("basic", 100);
      check("basic_first_ready", first_ready_cyc, c + 2);
      check("basic_seg0", seg_q.size() > 0 ? seg_q[0] : -1, 24);
      check("basic_tile3_rd", rd_rise_q.size() > 1 ? rd_rise_q[1] : -1, c + 52);
      check("basic_done_cyc", done_cyc, c + 61);
      check("basic_done_after_rd", done_cyc - last_rd_cyc, 2);
      check("basic_rows", ready_cnt, 32);
      check("basic_e_cnt", e_cnt, 8);
      check("basic_sb_empty", sb.size(), 0);
      check("basic_idle", {busy, done}, 0);
      repeat (3) @(negedge clk);

      // Early credit during tile 1, plus a start while busy that must be ignored.
      clear_log();
      push_exp(4);
      pulse_start(16'd4, c);
      while (cyc < c + 5) @(negedge clk);
      tile_no = 16'd9;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      pulse_fi_at(c + 12);
      wait_done("early", 100);
      check("early_one_burst", rd_rise_q.size(), 1);
      check("early_rd_cnt", rd_cnt, 32);
      check("early_seg0", seg_q.size() > 0 ? seg_q[0] : -1, 32);
      check("early_done_cyc", done_cyc, c + 34);
      check("early_sb_empty", sb.size(), 0);
      repeat (3) @(negedge clk);

      // Simultaneous fi and tile-3 row-0 read: credit holds, tile 4 follows with no stall.
      clear_log();
      push_exp(5);
      pulse_start(16'd5, c);
      pulse_fi_at(c + 20);
      pulse_fi_at(c + 25);
      check("simul_credit", dut.u_credit.cnt, 1);
      wait_done("simul", 100);
      check("simul_one_burst", rd_rise_q.size(), 1);
      check("simul_rd_cnt", rd_cnt, 40);
      check("simul_done_cyc", done_cyc, c + 42);
      check("simul_sb_empty", sb.size(), 0);
      repeat (3) @(negedge clk);

      // tile_no == 0: done one cycle after start, no reads, busy never rises.
      clear_log();
      pulse_start(16'd0, c);
      check("zero_done", {done, busy}, 2'b10);
      repeat (4) @(negedge clk);
      check("zero_rd_cnt", rd_cnt, 0);
      check("zero_busy_cnt", busy_cnt, 0);
      check("zero_done_cnt", done_cnt, 1);

      // Reset at row 5 of tile 1, then a fresh run from address 0.
      clear_log();
      push_exp(2);
      pulse_start(16'd2, c);
      while (cyc < c + 14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_quiet("midrst");
      check("midrst_rows", ready_cnt, 13);
      sb.delete();
      repeat (2) @(negedge clk);
      clear_log();
      push_exp(2);
      pulse_start(16'd2, c);
      wait_done("replay", 60);
      check("replay_first_ready", first_ready_cyc, c + 2);
      check("replay_rows", ready_cnt, 16);
      check("replay_sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tsqr_tile_feeder.md
Name: tsqr_tile_feeder

Overview:
- Sequencer that streams U/P tiles from a source row memory into the single-core TSQR datapath (ug_i/pg_i with ready strobes).
- The first tile carries the per-row e_ug/e_pg/e_upg scalars.
- The first PRELOAD tiles issue back-to-back; each later tile is gated by a tile-finished credit from the core (mem0_fi/mem1_fi style).
- Replaces the hand-sequenced stimulus feeding tsqr_st8_1c and becomes the on-chip front end of the TSQR tile.

Parameters:
- MATRIX_WIDTH, 8, rows per tile (also the row count per tile burst).
- RAM_WIDTH, 256, width of one ug/pg row word.
- CNT_WIDTH, 16, width of tile_no and the tile counter.
- ADDR_WIDTH, 16, source memory address width.
- PRELOAD, 3, tiles issued without waiting for credit (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle launch pulse; ignored while busy=1.
- tile_no  in  CNT_WIDTH  number of tiles; sampled on an accepted start.
- core_tile_fi  in  1  one-cycle pulse from the core; each pulse returns one tile credit.
- src_rd_en  out  1  source memory read enable.
- src_rd_addr  out  ADDR_WIDTH  read address = tile_idx*MATRIX_WIDTH + row_idx.
- src_ug_data  in  RAM_WIDTH  U row data; valid one cycle after src_rd_en.
- src_pg_data  in  RAM_WIDTH  P row data; same timing as src_ug_data.
- src_e_ug, src_e_pg, src_e_upg  in  32 each  per-row scalars; same timing as src_ug_data.
- ug_i, pg_i  out  RAM_WIDTH  row data to the core.
- ug_ready, pg_ready  out  1  row valid; always equal to each other.
- e_ug, e_pg, e_upg  out  32 each  scalars to the core.
- e_ug_ready, e_pg_ready, e_upg_ready  out  1  scalar valid; asserted only for rows of tile 0.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last row is presented.

Behaviour:
- Reset: synchronous, active-high; clears everything at the next edge regardless of state, with no flush of an in-flight row.
  - All outputs 0 (data buses, scalars, all ready strobes, rd_en, addr, busy, done).
  - FSM to IDLE; counters and credits cleared.
- State IDLE:
  - start with tile_no>0: latch tile_no, tile_idx=0, row_idx=0, credits=PRELOAD, busy=1, go to FEED.
  - start with tile_no==0: done pulses on the next cycle; no reads are issued; busy never rises.
- State FEED: one read per cycle, rows 0..MATRIX_WIDTH-1 of tile tile_idx.
  - Credit is decremented on the cycle row 0 is read.
  - After the row MATRIX_WIDTH-1 read:
    - If it was the last tile, go to DRAIN.
    - Otherwise tile_idx+1; go to FEED if credits (after this cycle's update) are >0, else WAIT_FI.
  - Consecutive tiles with credit stream with no bubble.
- State WAIT_FI: src_rd_en=0; go to FEED on the cycle credits>0 (registered next state).
- State DRAIN: one cycle for the final read-data return. Then done=1 for one cycle, busy=0, go to IDLE.
- Output pipeline: read latency is 1, and outputs are registered on return data.
  - ug_ready/pg_ready go high exactly one cycle after the matching src_rd_en.
  - ug_i/pg_i/e_* update only on those cycles and hold their last value otherwise.
  - e_*_ready follow ug_ready, but only for tile_idx==0.
- Credit counter: 4 bits, saturating at 15.
  - +1 per core_tile_fi; -1 per tile start.
  - If both happen in the same cycle the count is unchanged.
  - core_tile_fi is counted in every non-IDLE state, including FEED.
  - core_tile_fi in IDLE is ignored.
- Address arithmetic: tile_idx*MATRIX_WIDTH with a power-of-two shift, truncated to ADDR_WIDTH; no overflow flag.
- A start pulse while busy is dropped with no side effect.

Decomposition:
- Shared package tsqr_pkg: MATRIX_WIDTH, RAM_WIDTH, CNT_WIDTH, RAM_ADDR_WIDTH constants, and a feeder_state_t enum {IDLE, FEED, WAIT_FI, DRAIN}.
- One natural sub-module: tsqr_credit_cnt (saturating up/down counter with simultaneous inc/dec).
- FSM, address generation and output register stay in the top.

Test Plan:
- Basic run: tile_no=4, PRELOAD=3, core_tile_fi pulsed 50 cycles after start.
  - Tiles 0-2 stream back-to-back: 24 contiguous ready cycles starting 2 cycles after start.
  - Tile 3 begins 2 cycles after the fi pulse.
  - done occurs 2 cycles after the last read; the 32 ug_i rows match source addresses 0..31.
- e strobes: e_*_ready high for exactly the first 8 ready cycles.
  - e_ug value sequence equals src_e_ug at addresses 0..7.
- Early credit: core_tile_fi pulsed during the tile-1 burst with tile_no=4.
  - Tile 3 follows tile 2 with zero bubble; WAIT_FI is never entered.
- Simultaneous events: fi pulse on the same cycle as the tile-3 row-0 read, with PRELOAD=3, tile_no=5.
  - Credits stay constant, and tile 4 streams with no stall.
- Boundaries: tile_no=0 gives a done pulse 1 cycle after start, with zero rd_en and busy=0; a start issued while busy has no effect.
- Reset mid-FEED (row 5 of tile 1): rst high for 1 cycle.
  - Next cycle: all outputs 0, busy=0.
  - A subsequent start replays from address 0.
